// File: rtl/pipe_ctrl.sv
// Pipeline hazard/control unit: load-use stalls, external full-pipeline holds,
// post-jump squash sequencing and a saturating stalled-cycle counter.
module pipe_ctrl #(
  parameter int unsigned JUMP_FLUSH_CYCLES = 1,
  parameter int unsigned STALL_CNT_W       = 16
) (
  input  logic                   clk_100MHz,
  input  logic                   arst_n,
  input  logic [4:0]             id_rs1_addr_i,
  input  logic [4:0]             id_rs2_addr_i,
  input  logic                   id_rs1_used_i,
  input  logic                   id_rs2_used_i,
  input  logic                   ex_mem_r_ena_i,
  input  logic [4:0]             ex_reg_w_addr_i,
  input  logic                   ex_jump_req_i,
  input  logic [31:0]            ex_jump_addr_i,
  input  logic                   ext_hold_req_i,
  output logic                   pc_hold_o,
  output logic                   if_id_hold_o,
  output logic                   id_ex_hold_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_flush_o,
  output logic                   pc_jump_ena_o,
  output logic [31:0]            pc_jump_addr_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(JUMP_FLUSH_CYCLES);

  state_t      state, state_nx;
  logic [2:0]  flush_cnt, flush_cnt_nx;
  logic        pend_v, pend_v_nx;
  logic [31:0] pend_addr, pend_addr_nx;
  logic        load_use;

  assign load_use = ex_mem_r_ena_i && (ex_reg_w_addr_i != '0) &&
                    ((id_rs1_used_i && (id_rs1_addr_i == ex_reg_w_addr_i)) ||
                     (id_rs2_used_i && (id_rs2_addr_i == ex_reg_w_addr_i)));

  always_comb begin
    pc_hold_o      = 1'b0;
    if_id_hold_o   = 1'b0;
    id_ex_hold_o   = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    pc_jump_ena_o  = 1'b0;
    pc_jump_addr_o = '0;
    state_nx       = state;
    flush_cnt_nx   = flush_cnt;
    pend_v_nx      = pend_v;
    pend_addr_nx   = pend_addr;

    if (!arst_n) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (ext_hold_req_i) begin
      pc_hold_o    = 1'b1;
      if_id_hold_o = 1'b1;
      id_ex_hold_o = 1'b1;
      state_nx     = HOLD;
      if (ex_jump_req_i && !pend_v) begin
        pend_v_nx    = 1'b1;
        pend_addr_nx = ex_jump_addr_i;
      end
    end else if (pend_v || ex_jump_req_i) begin
      // A parked jump is the same EX instruction still asserting its request,
      // so the latched target wins and the live request is ignored.
      pc_jump_ena_o  = 1'b1;
      pc_jump_addr_o = pend_v ? pend_addr : ex_jump_addr_i;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      pend_v_nx      = 1'b0;
      flush_cnt_nx   = FLUSH_INIT;
      state_nx       = (FLUSH_INIT == '0) ? RUN : FLUSH;
    end else if ((state != RUN) && (flush_cnt != '0)) begin
      // Also resumes a squash countdown that an ext hold interrupted.
      if_id_flush_o = 1'b1;
      flush_cnt_nx  = flush_cnt - 3'd1;
      state_nx      = (flush_cnt == 3'd1) ? RUN : FLUSH;
    end else begin
      state_nx = RUN;
      if (load_use) begin
        pc_hold_o     = 1'b1;
        if_id_hold_o  = 1'b1;
        id_ex_flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      state       <= RUN;
      flush_cnt   <= '0;
      pend_v      <= 1'b0;
      pend_addr   <= '0;
      stall_cnt_o <= '0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
      pend_v    <= pend_v_nx;
      pend_addr <= pend_addr_nx;
      if (pc_hold_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one table row per clock cycle, plus
// hand-written saturation and reset-during-hold sequences.
module tb_pipe_ctrl;

  logic        clk_100MHz = 1'b0;
  logic        arst_n;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_reg_w_addr_i;
  logic        id_rs1_used_i, id_rs2_used_i, ex_mem_r_ena_i;
  logic        ex_jump_req_i, ext_hold_req_i;
  logic [31:0] ex_jump_addr_i;
  logic        pc_hold_o, if_id_hold_o, id_ex_hold_o;
  logic        if_id_flush_o, id_ex_flush_o, pc_jump_ena_o;
  logic [31:0] pc_jump_addr_o;
  logic [3:0]  stall_cnt_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  pipe_ctrl #(.JUMP_FLUSH_CYCLES(1), .STALL_CNT_W(4)) dut (
    .clk_100MHz     (clk_100MHz),
    .arst_n         (arst_n),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rs1_used_i  (id_rs1_used_i),
    .id_rs2_used_i  (id_rs2_used_i),
    .ex_mem_r_ena_i (ex_mem_r_ena_i),
    .ex_reg_w_addr_i(ex_reg_w_addr_i),
    .ex_jump_req_i  (ex_jump_req_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .ext_hold_req_i (ext_hold_req_i),
    .pc_hold_o      (pc_hold_o),
    .if_id_hold_o   (if_id_hold_o),
    .id_ex_hold_o   (id_ex_hold_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .pc_jump_ena_o  (pc_jump_ena_o),
    .pc_jump_addr_o (pc_jump_addr_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  // ctl = {pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, pc_jump_ena}
  typedef struct {
    string       name;
    logic        rst_n;
    logic [4:0]  rs1, rs2;
    logic        u1, u2, ld;
    logic [4:0]  rd;
    logic        jreq;
    logic [31:0] jaddr;
    logic        ext;
    logic [5:0]  ctl;
    logic [31:0] ja;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst_n, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic ld, logic [4:0] rd, logic jreq,
                              logic [31:0] jaddr, logic ext, logic [5:0] ctl,
                              logic [31:0] ja, logic [3:0] cnt);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.ld = ld; v.rd = rd; v.jreq = jreq; v.jaddr = jaddr; v.ext = ext;
    v.ctl = ctl; v.ja = ja; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(logic rst_n, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                       logic ld, logic [4:0] rd, logic jreq, logic [31:0] jaddr, logic ext);
    arst_n = rst_n; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
    id_rs1_used_i = u1; id_rs2_used_i = u2; ex_mem_r_ena_i = ld;
    ex_reg_w_addr_i = rd; ex_jump_req_i = jreq; ex_jump_addr_i = jaddr;
    ext_hold_req_i = ext;
  endtask

  task automatic check(string name, logic [5:0] ctl, logic [31:0] ja, logic [3:0] cnt);
    logic [5:0] act_ctl;
    act_ctl = {pc_hold_o, if_id_hold_o, id_ex_hold_o, if_id_flush_o, id_ex_flush_o, pc_jump_ena_o};
    n_tests++;
    if (act_ctl !== ctl || pc_jump_addr_o !== ja || stall_cnt_o !== cnt) begin
      n_fail++;
      $display("FAIL %s: ctl=%b addr=%h cnt=%0d, required ctl=%b addr=%h cnt=%0d",
               name, act_ctl, pc_jump_addr_o, stall_cnt_o, ctl, ja, cnt);
    end
  endtask

  initial begin
    // Reset and load-use
    vecs.push_back(mk("rst0",      0, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000110, 32'h0,   0));
    vecs.push_back(mk("rst1",      0, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000110, 32'h0,   0));
    vecs.push_back(mk("run_idle",  1, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000000, 32'h0,   0));
    vecs.push_back(mk("lu_rs2",    1, 0,5, 0,1, 1,5, 0,32'h0,   0, 6'b110010, 32'h0,   0));
    vecs.push_back(mk("lu_bubble", 1, 0,5, 0,1, 0,0, 0,32'h0,   0, 6'b000000, 32'h0,   1));
    vecs.push_back(mk("lu_x0",     1, 0,0, 1,1, 1,0, 0,32'h0,   0, 6'b000000, 32'h0,   1));
    vecs.push_back(mk("lu_unused", 1, 7,0, 0,0, 1,7, 0,32'h0,   0, 6'b000000, 32'h0,   1));
    vecs.push_back(mk("lu_rs1",    1, 9,0, 1,0, 1,9, 0,32'h0,   0, 6'b110010, 32'h0,   1));
    // Jump with one extra IF/ID flush cycle
    vecs.push_back(mk("jmp",       1, 0,0, 0,0, 0,0, 1,32'h100, 0, 6'b000111, 32'h100, 2));
    vecs.push_back(mk("jmp_fl1",   1, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000100, 32'h0,   2));
    vecs.push_back(mk("jmp_done",  1, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000000, 32'h0,   2));
    // Ext hold four cycles with a jump parked in the first
    vecs.push_back(mk("hold1",     1, 0,0, 0,0, 0,0, 1,32'h200, 1, 6'b111000, 32'h0,   2));
    vecs.push_back(mk("hold2",     1, 0,0, 0,0, 0,0, 1,32'h200, 1, 6'b111000, 32'h0,   3));
    vecs.push_back(mk("hold3",     1, 0,0, 0,0, 0,0, 0,32'h0,   1, 6'b111000, 32'h0,   4));
    vecs.push_back(mk("hold4",     1, 0,0, 0,0, 0,0, 0,32'h0,   1, 6'b111000, 32'h0,   5));
    vecs.push_back(mk("hold_rel",  1, 0,0, 0,0, 0,0, 1,32'h300, 0, 6'b000111, 32'h200, 6));
    vecs.push_back(mk("rel_fl1",   1, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000100, 32'h0,   6));
    vecs.push_back(mk("rel_done",  1, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000000, 32'h0,   6));
    // Jump coinciding with load-use, then hazard visible during the flush cycle
    vecs.push_back(mk("jmp_lu",    1, 3,0, 1,0, 1,3, 1,32'h40,  0, 6'b000111, 32'h40,  6));
    vecs.push_back(mk("fl_lu",     1, 3,0, 1,0, 1,3, 0,32'h0,   0, 6'b000100, 32'h0,   6));
    vecs.push_back(mk("jlu_done",  1, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000000, 32'h0,   6));
    // New jump during FLUSH restarts the sequence
    vecs.push_back(mk("jmp_a",     1, 0,0, 0,0, 0,0, 1,32'h80,  0, 6'b000111, 32'h80,  6));
    vecs.push_back(mk("jmp_b",     1, 0,0, 0,0, 0,0, 1,32'h90,  0, 6'b000111, 32'h90,  6));
    vecs.push_back(mk("jb_fl1",    1, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000100, 32'h0,   6));
    vecs.push_back(mk("jb_done",   1, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000000, 32'h0,   6));
    // Ext hold interrupting FLUSH freezes the countdown
    vecs.push_back(mk("jmp_c",     1, 0,0, 0,0, 0,0, 1,32'hA0,  0, 6'b000111, 32'hA0,  6));
    vecs.push_back(mk("fl_hold",   1, 0,0, 0,0, 0,0, 0,32'h0,   1, 6'b111000, 32'h0,   6));
    vecs.push_back(mk("fl_resume", 1, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000100, 32'h0,   7));
    vecs.push_back(mk("fl_done",   1, 0,0, 0,0, 0,0, 0,32'h0,   0, 6'b000000, 32'h0,   7));

    drive(0, 0,0, 0,0, 0,0, 0,32'h0, 0);
    @(posedge clk_100MHz);

    foreach (vecs[i]) begin
      @(posedge clk_100MHz); #1;
      drive(vecs[i].rst_n, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].ld, vecs[i].rd, vecs[i].jreq, vecs[i].jaddr, vecs[i].ext);
      @(negedge clk_100MHz);
      check(vecs[i].name, vecs[i].ctl, vecs[i].ja, vecs[i].cnt);
    end

    // Saturation: 20 held cycles from count 7; a jump is parked in the first
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_100MHz); #1;
      drive(1, 0,0, 0,0, 0,0, (i == 0), 32'h500, 1);
      @(negedge clk_100MHz);
      check("sat_hold", 6'b111000, 32'h0, (7 + i > 15) ? 4'd15 : 4'(7 + i));
    end
    @(posedge clk_100MHz); #1;
    drive(1, 0,0, 0,0, 0,0, 0,32'h0, 1);
    @(negedge clk_100MHz);
    check("sat_final", 6'b111000, 32'h0, 4'd15);

    // Reset mid-HOLD: flushes during reset, pending jump discarded afterwards
    @(posedge clk_100MHz); #1;
    drive(0, 0,0, 0,0, 0,0, 0,32'h0, 1);
    @(negedge clk_100MHz);
    check("rst_in_hold", 6'b000110, 32'h0, 4'd15);
    @(posedge clk_100MHz); #1;
    drive(1, 0,0, 0,0, 0,0, 0,32'h0, 0);
    @(negedge clk_100MHz);
    check("rst_no_pend", 6'b000000, 32'h0, 4'd0);
    @(posedge clk_100MHz); #1;
    drive(1, 0,4, 0,1, 1,4, 0,32'h0, 0);
    @(negedge clk_100MHz);
    check("post_rst_lu", 6'b110010, 32'h0, 4'd0);
    @(posedge clk_100MHz); #1;
    drive(1, 0,0, 0,0, 0,0, 0,32'h0, 0);
    @(negedge clk_100MHz);
    check("post_rst_cnt", 6'b000000, 32'h0, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
